// File: rtl/out_stage_pkg.sv
// out_stage_pkg: shared sizing defaults and FSM state type for the output stage
package out_stage_pkg;
  localparam int DEF_HIDDEN = 768;
  localparam int DEF_ACT_BITWIDTH = 4;
  localparam int DEF_BEAT_ELEMS = 16;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
endpackage

// File: rtl/out_stage_beat_argmax.sv
// beat_argmax: signed maximum of one beat, ties resolved to the lowest element index
module beat_argmax
  import out_stage_pkg::*;
#(
  parameter int N = DEF_BEAT_ELEMS,
  parameter int W = DEF_ACT_BITWIDTH,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N*W-1:0]      data_i,
  output logic signed [W-1:0] max_o,
  output logic [IW-1:0]       idx_o
);
  always_comb begin
    max_o = $signed(data_i[W-1:0]);
    idx_o = '0;
    for (int i = 1; i < N; i++)
      if ($signed(data_i[i*W +: W]) > max_o) begin
        max_o = $signed(data_i[i*W +: W]);
        idx_o = IW'(i);
      end
  end
endmodule

// File: rtl/out_stage.sv
// out_stage: streams the final hidden vector as beats and tracks its signed argmax
module out_stage
  import out_stage_pkg::*;
#(
  parameter int HIDDEN = DEF_HIDDEN,
  parameter int ACT_BITWIDTH = DEF_ACT_BITWIDTH,
  parameter int BEAT_ELEMS = DEF_BEAT_ELEMS,
  localparam int IW = $clog2(HIDDEN)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               out_start,
  input  logic [HIDDEN*ACT_BITWIDTH-1:0]     in_vec,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [BEAT_ELEMS*ACT_BITWIDTH-1:0] m_data,
  output logic                               m_last,
  output logic                               out_done,
  output logic                               busy,
  output logic signed [ACT_BITWIDTH-1:0]     max_val,
  output logic [IW-1:0]                      max_idx
);
  localparam int BEATS = HIDDEN / BEAT_ELEMS;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int BIW = BEAT_ELEMS > 1 ? $clog2(BEAT_ELEMS) : 1;
  localparam int BB = BEAT_ELEMS * ACT_BITWIDTH;
  localparam logic signed [ACT_BITWIDTH-1:0] SMIN = {1'b1, {(ACT_BITWIDTH-1){1'b0}}};
  state_e state_q, state_d;
  logic [HIDDEN*ACT_BITWIDTH-1:0] buf_q, buf_d;
  logic [BW-1:0] beat_q, beat_d;
  logic signed [ACT_BITWIDTH-1:0] run_max_q, run_max_d, max_val_q, max_val_d, beat_max;
  logic [IW-1:0] run_idx_q, run_idx_d, max_idx_q, max_idx_d, beat_gidx;
  logic [BIW-1:0] beat_idx;
  logic last_beat;
  assign m_data = buf_q[int'(beat_q)*BB +: BB];
  assign m_valid = state_q == SEND;
  assign last_beat = beat_q == BW'(BEATS - 1);
  assign m_last = m_valid && last_beat;
  assign out_done = state_q == DONE;
  assign busy = state_q != IDLE;
  assign max_val = max_val_q;
  assign max_idx = max_idx_q;
  assign beat_gidx = IW'(int'(beat_q) * BEAT_ELEMS + int'(beat_idx));
  beat_argmax #(.N(BEAT_ELEMS), .W(ACT_BITWIDTH)) u_argmax (
    .data_i(m_data),
    .max_o (beat_max),
    .idx_o (beat_idx)
  );
  // strict > keeps the earlier beat on a global tie, so the lowest index wins
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    beat_d = beat_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    case (state_q)
      IDLE: if (out_start) begin
        state_d = SEND;
        buf_d = in_vec;
        beat_d = '0;
        run_max_d = SMIN;
        run_idx_d = '0;
      end
      SEND: if (m_ready) begin
        if (beat_max > run_max_q) begin
          run_max_d = beat_max;
          run_idx_d = beat_gidx;
        end
        state_d = last_beat ? DONE : SEND;
        beat_d = last_beat ? beat_q : beat_q + 1'b1;
        max_val_d = last_beat ? run_max_d : max_val_q;
        max_idx_d = last_beat ? run_idx_d : max_idx_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      buf_q <= '0;
      beat_q <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      beat_q <= beat_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
    end
endmodule

// File: tb/tb_out_stage.sv
// tb_out_stage: table-driven and randomized checks of beat streaming and argmax
module tb_out_stage;
  localparam int H = 768, W = 4, BE = 16, NB = H / BE, VW = H * W;
  logic clk = 0, rst = 1, out_start = 0, m_ready = 0;
  logic [VW-1:0] in_vec = '0;
  logic m_valid, m_last, out_done, busy;
  logic [BE*W-1:0] m_data;
  logic signed [W-1:0] max_val;
  logic [9:0] max_idx;
  int total = 0, bad = 0;
  typedef struct {
    logic [VW-1:0] v;
    logic signed [W-1:0] ev;
    int ei;
    bit stall;
    int poke;
  } vec_t;
  vec_t tbl[7];
  always #5 clk = ~clk;
  out_stage dut (
    .clk(clk), .rst(rst), .out_start(out_start), .in_vec(in_vec),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .out_done(out_done), .busy(busy), .max_val(max_val), .max_idx(max_idx)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // whole-vector argmax: first occurrence of the largest signed element
  task automatic ref_max(input logic [VW-1:0] v, output logic signed [W-1:0] mv, output int mi);
    mv = -8;
    mi = 0;
    for (int i = 0; i < H; i++)
      if ($signed(v[i*W +: W]) > mv) begin
        mv = $signed(v[i*W +: W]);
        mi = i;
      end
  endtask
  task automatic xfer(input vec_t t, input string nm);
    int beat = 0, stall_left = 0;
    bit fin = 0, pv = 0, pr = 1;
    logic [BE*W-1:0] pd = '0;
    logic pl = 0;
    @(negedge clk);
    in_vec = t.v;
    out_start = 1;
    m_ready = 1;
    for (int k = 1; k <= 1000 && !fin; k++) begin
      @(negedge clk);
      out_start = 0;
      if (k == t.poke) begin
        out_start = 1;
        in_vec = ~t.v;
      end
      if (k == 1) chk({nm, "_busy"}, busy, 1);
      if (out_done) begin
        chk({nm, "_max_val"}, max_val, t.ev);
        chk({nm, "_max_idx"}, max_idx, t.ei);
        chk({nm, "_nbeats"}, beat, NB);
        chk({nm, "_valid_in_done"}, m_valid, 0);
        if (!t.stall) chk({nm, "_latency"}, k, NB + 1);
        fin = 1;
      end else begin
        chk({nm, "_valid"}, m_valid, 1);
        if (pv && !pr) begin
          chk({nm, "_stall_data"}, m_data, pd);
          chk({nm, "_stall_last"}, m_last, pl);
        end
        chk({nm, "_data"}, m_data, t.v[beat*BE*W +: BE*W]);
        chk({nm, "_last"}, m_last, beat == NB - 1);
        pd = m_data;
        pl = m_last;
        pv = 1;
        if (t.stall && stall_left > 0) begin
          m_ready = 0;
          stall_left--;
        end else if (t.stall && $urandom_range(0, 3) == 0) begin
          m_ready = 0;
          stall_left = 2;
        end else m_ready = 1;
        pr = m_ready;
        if (m_ready) beat++;
      end
    end
    if (!fin) chk({nm, "_timeout"}, 0, 1);
    out_start = 0;
    m_ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk({nm, "_no_extra_done"}, out_done, 0);
      chk({nm, "_idle"}, busy, 0);
      chk({nm, "_hold_val"}, max_val, t.ev);
      chk({nm, "_hold_idx"}, max_idx, t.ei);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    logic [VW-1:0] v;
    logic signed [W-1:0] mv;
    int mi, lim;
    for (int i = 0; i < H; i++) v[i*W +: W] = W'(i % 8);
    tbl[0] = '{v: v, ev: 7, ei: 7, stall: 0, poke: 0};
    for (int i = 0; i < H; i++) v[i*W +: W] = 4'h8;
    tbl[1] = '{v: v, ev: -8, ei: 0, stall: 0, poke: 5};
    v = '0;
    v[500*W +: W] = 4'd5;
    v[20*W +: W] = 4'd5;
    tbl[2] = '{v: v, ev: 5, ei: 20, stall: 0, poke: 0};
    v = '0;
    v[767*W +: W] = 4'd7;
    tbl[3] = '{v: v, ev: 7, ei: 767, stall: 1, poke: 0};
    for (int r = 4; r < 7; r++) begin
      lim = $urandom_range(3, 15);
      for (int i = 0; i < H; i++) v[i*W +: W] = W'(int'($urandom_range(0, lim)) - 8);
      ref_max(v, mv, mi);
      tbl[r] = '{v: v, ev: mv, ei: mi, stall: r != 6, poke: 0};
    end
    #3;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_done", out_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_max_val", max_val, 0);
    chk("rst_max_idx", max_idx, 0);
    @(negedge clk);
    rst = 0;
    for (int r = 0; r < 6; r++) xfer(tbl[r], $sformatf("vec%0d", r));
    @(negedge clk);
    in_vec = tbl[5].v;
    out_start = 1;
    m_ready = 1;
    repeat (11) begin
      @(negedge clk);
      out_start = 0;
    end
    chk("abort_beat10", m_data, tbl[5].v[10*BE*W +: BE*W]);
    #2 rst = 1;
    #1;
    chk("abort_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", out_done, 0);
    chk("abort_max_val", max_val, 0);
    @(negedge clk);
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_done", out_done, 0);
      chk("abort_idle", busy, 0);
    end
    xfer(tbl[6], "after_abort");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/out_stage.md
OUT_STAGE -- requirements
Module: out_stage

Interface
REQ-001 SHALL have parameter HIDDEN, default 768, meaning number of elements in the final hidden vector.
REQ-002 SHALL have parameter ACT_BITWIDTH, default 4, meaning signed two's-complement width of one activation element.
REQ-003 SHALL have parameter BEAT_ELEMS, default 16, meaning elements per output beat; HIDDEN SHALL be a multiple of BEAT_ELEMS (BEATS = HIDDEN/BEAT_ELEMS = 48 at defaults).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port out_start  input  1  single-cycle pulse from the model controller requesting output of the final layer vector.
REQ-008 SHALL have port in_vec  input  HIDDEN*ACT_BITWIDTH  final-layer activations; element i at bits [i*ACT_BITWIDTH +: ACT_BITWIDTH].
REQ-009 SHALL have port m_valid  output  1  output beat valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts beat.
REQ-011 SHALL have port m_data  output  BEAT_ELEMS*ACT_BITWIDTH  beat payload, lowest-index element at LSB.
REQ-012 SHALL have port m_last  output  1  marks final beat.
REQ-013 SHALL have port out_done  output  1  single-cycle completion pulse to the model controller.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port max_val  output  ACT_BITWIDTH  signed maximum element of the last completed vector.
REQ-016 SHALL have port max_idx  output  $clog2(HIDDEN)  index of max_val.

Function
REQ-017 SHALL implement states IDLE, SEND, DONE.
REQ-018 In IDLE, out_start SHALL latch in_vec into an internal buffer, clear beat counter to 0, load running max to signed minimum (-8) with index 0, and enter SEND next cycle.
REQ-019 out_start while busy SHALL be ignored; buffer and counter SHALL not change.
REQ-020 In SEND, m_valid SHALL be 1 and m_data SHALL equal buffer elements [beat*BEAT_ELEMS .. beat*BEAT_ELEMS+BEAT_ELEMS-1].
REQ-021 m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-022 m_last SHALL be 1 exactly when beat counter equals BEATS-1 in SEND.
REQ-023 On a handshake (m_valid&&m_ready), the running max SHALL update from the beat: beat-local argmax with ties to lowest index, replacing the running max only if strictly greater (global ties resolve to lowest index).
REQ-024 On a handshake with beat counter BEATS-1 SHALL enter DONE; otherwise SHALL increment the counter.
REQ-025 In DONE, out_done SHALL be 1 for exactly one cycle, max_val/max_idx SHALL present the final result, then return to IDLE.
REQ-026 max_val/max_idx SHALL hold their value from DONE until the next DONE.
REQ-027 Latency: out_start at cycle T gives m_valid at T+1; with m_ready constantly 1, out_done at T+1+BEATS (T+49 at defaults).
REQ-028 m_valid SHALL be 0 in IDLE and DONE.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, m_valid=0, m_last=0, out_done=0, busy=0, max_val=0, max_idx=0, beat counter=0.
REQ-030 rst asserted mid-transfer SHALL abort without an out_done pulse; the first out_start after deassertion SHALL start a fresh transfer.

Structure
REQ-031 A shared package SHALL hold HIDDEN, ACT_BITWIDTH, BEAT_ELEMS defaults and the state enum type.
REQ-032 A combinational sub-module beat_argmax SHALL compute the beat-local signed maximum and lowest index.

Verification
REQ-033 Ramp in_vec[i]=i mod 8 (0..7), m_ready=1 -> 48 beats in order, m_last on beat 47, out_done at T+49, max_val=7, max_idx=7.
REQ-034 All elements -8 -> max_val=-8, max_idx=0.
REQ-035 Element 500=+5, element 20=+5, others 0 -> max_idx=20; element 767=+7 only -> max_idx=767.
REQ-036 m_ready toggled randomly with 3-cycle stalls -> m_data/m_last stable during stalls, no beats lost or duplicated.
REQ-037 Second out_start during SEND -> ignored, only one out_done; rst at beat 10 -> m_valid drops immediately, no out_done, next out_start transfers from beat 0.
